dmd_capture: RTL

Captures a 128×32 monochrome pinball DMD stream (dot clock, serial data, row clock, row-0 marker) into a double-buffered frame store. Serves random-access dot lookups to the downstream LCD video generator, which maps each dot to a 10×10 LCD cell. All DMD inputs are asynchronous; they are sampled as data in the single `clk` domain. Only complete frames are ever presented.

---
 rtl/dmd_capture_pkg.sv | 32 +++
 rtl/dmd_capture_if.sv | 26 ++
 rtl/dmd_capture_edge_sync.sv | 35 +++
 rtl/dmd_capture.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dmd_capture_pkg.sv
// Shared constants and types for the DMD frame capture block.
package dmd_pkg;
  localparam int DMD_COLS = 128;
  localparam int DMD_ROWS = 32;
  localparam int DMD_XW   = 7;
  localparam int DMD_YW   = 5;

  typedef logic [DMD_COLS-1:0] dmd_row_t;

  // What a row-clock edge does, given the marker and where the row pointer sits.
  typedef enum logic [2:0] {
    CMT_IGNORE,
    CMT_WRITE,
    CMT_RESYNC,
    CMT_SWAP,
    CMT_ABORT,
    CMT_DROP
  } dmd_cmt_e;

  function automatic dmd_cmt_e dmd_commit_kind(input logic marker,
                                               input logic ptr_zero,
                                               input logic ptr_full);
    if (marker) begin
      if (ptr_full) return CMT_SWAP;
      if (ptr_zero) return CMT_RESYNC;
      return CMT_ABORT;
    end
    if (ptr_full) return CMT_DROP;
    if (ptr_zero) return CMT_IGNORE;
    return CMT_WRITE;
  endfunction
endpackage

// File: rtl/dmd_capture_if.sv
// DMD pin bundle, dot lookup port and frame status for dmd_capture.
interface dmd_capture_if;
  import dmd_pkg::*;

  logic              dmd_dotclk;
  logic              dmd_sdata;
  logic              dmd_rclk;
  logic              dmd_rdata;
  logic [DMD_XW-1:0] rd_x;
  logic [DMD_YW-1:0] rd_y;
  logic              rd_dot;
  logic              frame_valid;
  logic              frame_strobe;
  logic              err_frame;
  logic              err_ovf;

  modport master (
    output dmd_dotclk, dmd_sdata, dmd_rclk, dmd_rdata, rd_x, rd_y,
    input  rd_dot, frame_valid, frame_strobe, err_frame, err_ovf
  );

  modport slave (
    input  dmd_dotclk, dmd_sdata, dmd_rclk, dmd_rdata, rd_x, rd_y,
    output rd_dot, frame_valid, frame_strobe, err_frame, err_ovf
  );
endinterface

// File: rtl/dmd_capture_edge_sync.sv
// Synchronizer for one asynchronous DMD pin; clock pins add a history flop
// and report a one-cycle rising-edge pulse, data pins report the synced level.
module dmd_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit DETECT_RISE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], din};

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  if (DETECT_RISE) begin : g_rise
    logic hist_q, hist_d;

    always_comb hist_d = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (!rst_n) hist_q <= 1'b0;
      else        hist_q <= hist_d;
    end

    assign dout = sync_q[SYNC_STAGES-1] & ~hist_q;
  end else begin : g_level
    assign dout = sync_q[SYNC_STAGES-1];
  end
endmodule

// File: rtl/dmd_capture.sv
// Captures the serial DMD stream into a double-buffered frame store and
// serves registered single-dot lookups from the buffer currently on display.
module dmd_capture
  import dmd_pkg::*;
#(
  parameter int COLS        = DMD_COLS,
  parameter int ROWS        = DMD_ROWS,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  dmd_capture_if.slave bus
);
  localparam int PW = $clog2(ROWS + 1);
  localparam int YW = $clog2(ROWS);
  localparam int CW = $clog2(COLS + 1);

  logic dot_rise, sdata_s, rclk_rise, rdata_s;

  dmd_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .DETECT_RISE(1'b1)) u_sync_dotclk (
    .clk(clk), .rst_n(rst_n), .din(bus.dmd_dotclk), .dout(dot_rise));
  dmd_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .DETECT_RISE(1'b0)) u_sync_sdata (
    .clk(clk), .rst_n(rst_n), .din(bus.dmd_sdata), .dout(sdata_s));
  dmd_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .DETECT_RISE(1'b1)) u_sync_rclk (
    .clk(clk), .rst_n(rst_n), .din(bus.dmd_rclk), .dout(rclk_rise));
  dmd_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .DETECT_RISE(1'b0)) u_sync_rdata (
    .clk(clk), .rst_n(rst_n), .din(bus.dmd_rdata), .dout(rdata_s));

  logic [COLS-1:0] sr_q, sr_d;
  logic [CW-1:0]   dot_cnt_q, dot_cnt_d;
  logic [PW-1:0]   row_ptr_q, row_ptr_d;
  logic            disp_sel_q, disp_sel_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_strobe_q, frame_strobe_d;
  logic            err_frame_q, err_frame_d;
  logic            err_ovf_q, err_ovf_d;
  logic            rd_dot_q, rd_dot_d;

  logic [COLS-1:0] frame_mem [2][ROWS];
  logic            wr_en, wr_sel;
  logic [YW-1:0]   wr_row;
  dmd_cmt_e        cmt;

  always_comb begin
    sr_d           = sr_q;
    dot_cnt_d      = dot_cnt_q;
    row_ptr_d      = row_ptr_q;
    disp_sel_d     = disp_sel_q;
    frame_valid_d  = frame_valid_q;
    frame_strobe_d = 1'b0;
    err_frame_d    = 1'b0;
    err_ovf_d      = 1'b0;
    wr_en          = 1'b0;
    wr_sel         = ~disp_sel_q;
    wr_row         = '0;
    cmt            = dmd_commit_kind(rdata_s, row_ptr_q == '0, row_ptr_q == PW'(ROWS));

    if (dot_rise) begin
      sr_d = {sdata_s, sr_q[COLS-1:1]};
      if (dot_cnt_q != CW'(COLS)) dot_cnt_d = dot_cnt_q + CW'(1);
    end

    // The commit takes sr_q, so a coincident dot lands in the next row.
    if (rclk_rise) begin
      dot_cnt_d = dot_rise ? CW'(1) : '0;
      case (cmt)
        CMT_SWAP: begin
          frame_strobe_d = 1'b1;
          frame_valid_d  = 1'b1;
          disp_sel_d     = ~disp_sel_q;
          wr_sel         = disp_sel_q;
          wr_en          = 1'b1;
          row_ptr_d      = PW'(1);
        end
        CMT_ABORT: begin
          err_frame_d = 1'b1;
          wr_en       = 1'b1;
          row_ptr_d   = PW'(1);
        end
        CMT_RESYNC: begin
          wr_en     = 1'b1;
          row_ptr_d = PW'(1);
        end
        CMT_WRITE: begin
          wr_en     = 1'b1;
          wr_row    = row_ptr_q[YW-1:0];
          row_ptr_d = row_ptr_q + PW'(1);
        end
        CMT_DROP: err_ovf_d = 1'b1;
        default: ;
      endcase
    end

    rd_dot_d = frame_valid_q & frame_mem[disp_sel_q][bus.rd_y][bus.rd_x];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q           <= '0;
      dot_cnt_q      <= '0;
      row_ptr_q      <= '0;
      disp_sel_q     <= 1'b0;
      frame_valid_q  <= 1'b0;
      frame_strobe_q <= 1'b0;
      err_frame_q    <= 1'b0;
      err_ovf_q      <= 1'b0;
      rd_dot_q       <= 1'b0;
    end else begin
      sr_q           <= sr_d;
      dot_cnt_q      <= dot_cnt_d;
      row_ptr_q      <= row_ptr_d;
      disp_sel_q     <= disp_sel_d;
      frame_valid_q  <= frame_valid_d;
      frame_strobe_q <= frame_strobe_d;
      err_frame_q    <= err_frame_d;
      err_ovf_q      <= err_ovf_d;
      rd_dot_q       <= rd_dot_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) frame_mem[wr_sel][wr_row] <= sr_q;
  end

  assign bus.rd_dot       = rd_dot_q;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.frame_strobe = frame_strobe_q;
  assign bus.err_frame    = err_frame_q;
  assign bus.err_ovf      = err_ovf_q;
endmodule
